lfsr_rng: RTL and testbench
===========================

# lfsr_rng

Parametrised random-number generator for the game logic: a free-running Fibonacci LFSR of configurable width and tap mask, plus a request/valid reduction engine that returns `(sample mod range) + offset` using a bit-serial restoring divider. It supersedes the fixed 5-bit generator and adds seed loading, lock-up protection, and a true modulo that needs no combinational divider. It sits between the game FSM, which issues requests, and the spawn/position logic, which consumes results.

## Interface
- `WIDTH`, 8: LFSR, range, offset and result width; must be ≥ 3.
- `TAPS`, 8'hB8: feedback mask, WIDTH bits. Feedback bit = XOR-reduce of (`lfsr` & `TAPS`).
- `SEED_DEFAULT`, 8'h01: LFSR value after reset; must be non-zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `seed_load` in 1: load `seed` into the LFSR this edge.
- `seed` in WIDTH: seed value.
- `req` in 1: request one reduced sample. Ignored while `busy`.
- `range` in WIDTH: modulus, sampled with `req`. A value of 0 means no reduction.
- `offset` in WIDTH: added to the remainder, sampled with `req`.
- `busy` out 1: reduction in progress.
- `valid` out 1: one-cycle pulse; `random_out` is new.
- `random_out` out WIDTH: last result. Held until the next `valid`.

## Operation
- **LFSR update, every edge:**
  - If `seed_load`: `lfsr <= (seed == 0) ? 1 : seed`.
  - Otherwise: `lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}`.
  - If the register is ever 0, the next value is forced to 1.
  - The LFSR never stalls, so the sampling instant is what provides the entropy.
- **FSM states:** IDLE, CALC.
  - **IDLE:** `busy`=0. On `req`=1:
    - Capture `dividend` = current `lfsr` (the pre-edge value), `divisor` = `range`, `off` = `offset`.
    - Clear `rem` (WIDTH+1 bits) and set `cnt` = WIDTH-1.
    - Go to CALC.
  - **CALC:** `busy`=1. Each edge:
    - `t = {rem[WIDTH-1:0], dividend[WIDTH-1]}`; shift `dividend` left by 1.
    - `rem <= (divisor != 0 && t >= divisor) ? t - divisor : t`.
    - `cnt` decrements.
    - On the edge where `cnt` = 0: `random_out <= final_rem[WIDTH-1:0] + off`, truncated mod 2^WIDTH; `valid <= 1`; go to IDLE.
- **`range` = 0:** no subtraction ever happens, so the remainder equals the captured sample and the result is `sample + offset`.
- **Ignored inputs during CALC:** `req` is ignored. Changes to `range` and `offset` have no effect because the captured copies are used.
- **`seed_load` during CALC:** updates the LFSR but does not affect the captured dividend.
- **Simultaneous `req` and `seed_load` in IDLE:** the captured sample is the pre-edge LFSR value.

## Timing
- **Reset values:**
  - `lfsr` = `SEED_DEFAULT`; state = IDLE.
  - `busy`=0, `valid`=0, `random_out`=0.
  - All capture registers = 0.
- **Reset mid-CALC:** aborts immediately. No `valid` is issued and `random_out` returns to 0.
- **Latency:**
  - `req` sampled at edge E0.
  - `busy`=1 in the WIDTH cycles following E0.
  - The final iteration runs at edge E0+WIDTH. `valid`=1 and the new `random_out` appear in the cycle after it.
  - `valid` drops at E0+WIDTH+1.
- **Throughput:** a new `req` may be accepted at E0+WIDTH+1, i.e. in the same cycle `valid` is high. Back-to-back requests therefore give one result per WIDTH+1 cycles.
- **`valid` width:** exactly one cycle per accepted request, never asserted otherwise.
- **`random_out` stability:** unchanged between `valid` pulses.

## Test plan
All scenarios use WIDTH=8, TAPS=8'hB8.
- **Reset:** assert `rst` asynchronously mid-cycle → `busy`/`valid`/`random_out` read 0 immediately; after release, `lfsr` steps 01→02→04→08→11 on successive edges.
- **Period and zero seed:**
  - Load `seed`=8'h01 and run 255 cycles → sequence returns to 8'h01 with no repeat earlier and never visits 0.
  - Load `seed`=0 → `lfsr` reads 8'h01.
- **Reduction:**
  - Hold `seed_load` with `seed`=200 for 2 cycles. On the second cycle assert `req` with `range`=7, `offset`=6 → `busy` for 8 cycles, then a single `valid` with `random_out`=10.
  - Repeat with `range`=1 → 6. With `range`=255 → 206.
- **Bypass and wrap:** sample 200 with `range`=0 and `offset`=6 → 206. Sample 200 with `range`=0 and `offset`=100 → 44 (mod-256 wrap).
- **Busy and overlap:**
  - Pulse `req` again during CALC, and change `range`/`offset`/`seed_load` mid-CALC → no extra `valid`, and the result still equals 10.
  - Issue the next `req` in the `valid` cycle → accepted, second `valid` follows 9 cycles after the first.
- **Reset mid-operation:** assert `rst` four cycles into CALC → no `valid` ever appears for that request; after release the next `req` completes normally.

Source files
------------

// File: rtl/lfsr_rng_if.sv
// Request/result bus between the game FSM (master) and the random-number
// generator (slave): seed loading, reduction request and the reduced result.
interface lfsr_rng_if #(
   parameter int WIDTH = 8
);
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic             req;
   logic [WIDTH-1:0] range;
   logic [WIDTH-1:0] offset;
   logic             busy;
   logic             valid;
   logic [WIDTH-1:0] random_out;

   modport master (
      output seed_load, seed, req, range, offset,
      input  busy, valid, random_out
   );

   modport slave (
      input  seed_load, seed, req, range, offset,
      output busy, valid, random_out
   );
endinterface

// File: rtl/lfsr_rng.sv
// Free-running Fibonacci LFSR with a request-driven (sample mod range) + offset
// reduction computed by a bit-serial restoring divider.
module lfsr_rng #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'h01
) (
   input  logic             clk,
   input  logic             rst,
   lfsr_rng_if.slave        bus,
   output logic [WIDTH-1:0] lfsr_o
);

   localparam int               CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] LFSR_ONE = WIDTH'(1);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] off_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH:0]   rem_d;
   logic [WIDTH:0]   trial_s;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             valid_q;
   logic [WIDTH-1:0] random_q;

   // A zero state would lock the shift register, so it is steered back to 1.
   always_comb begin
      lfsr_d = lfsr_q;
      if (bus.seed_load) begin
         lfsr_d = (bus.seed == '0) ? LFSR_ONE : bus.seed;
      end else if (lfsr_q == '0) begin
         lfsr_d = LFSR_ONE;
      end else begin
         lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
      end
   end

   // One restoring-division step; a zero divisor never subtracts.
   always_comb begin
      trial_s = {rem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
      rem_d   = trial_s;
      if ((divisor_q != '0) && (trial_s >= {1'b0, divisor_q})) begin
         rem_d = trial_s - {1'b0, divisor_q};
      end else begin
         rem_d = trial_s;
      end
   end

   // LFSR stepping plus the IDLE/CALC request sequencer with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q     <= SEED_DEFAULT;
         state_q    <= IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         off_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         random_q   <= '0;
      end else begin
         lfsr_q  <= lfsr_d;
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req) begin
                  dividend_q <= lfsr_q;
                  divisor_q  <= bus.range;
                  off_q      <= bus.offset;
                  rem_q      <= '0;
                  cnt_q      <= CNT_INIT;
                  busy_q     <= 1'b1;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
               rem_q      <= rem_d;
               cnt_q      <= cnt_q - CNT_ONE;
               if (cnt_q == '0) begin
                  random_q <= rem_d[WIDTH-1:0] + off_q;
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.valid      = valid_q;
   assign bus.random_out = random_q;
   assign lfsr_o         = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Scoreboard bench for lfsr_rng: a reference model queues expected results at
// request time and a negedge monitor pops and compares them on every valid.
module tb_lfsr_rng;
   localparam int W = 8;
   localparam logic [7:0] TAPS = 8'hB8;

   logic       clk;
   logic       rst;
   logic [7:0] lfsr_o;

   lfsr_rng_if #(.WIDTH(W)) ifc ();

   lfsr_rng #(.WIDTH(W), .TAPS(TAPS), .SEED_DEFAULT(8'h01)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (ifc),
      .lfsr_o(lfsr_o)
   );

   int errors = 0;
   int checks = 0;

   int m_lfsr;
   int m_left;
   int exp_q[$];
   int last_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int reduce_ref(input int s, input int r, input int o);
      int rem;
      rem = (r == 0) ? s : s % r;
      return (rem + o) % 256;
   endfunction

   function automatic int lfsr_step(input int x);
      if (x == 0) return 1;
      return ((x * 2) % 256) + ($countones(8'(x) & TAPS) % 2);
   endfunction

   // Reference model: one request in flight, W busy cycles, LFSR by its rule.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr = 1;
         m_left = 0;
         exp_q.delete();
      end else begin
         if (m_left == 0) begin
            if (ifc.req === 1'b1) begin
               exp_q.push_back(reduce_ref(m_lfsr, int'(ifc.range), int'(ifc.offset)));
               m_left = W;
            end
         end else begin
            m_left--;
         end
         if (ifc.seed_load === 1'b1) m_lfsr = (ifc.seed == 8'd0) ? 1 : int'(ifc.seed);
         else m_lfsr = lfsr_step(m_lfsr);
      end
   end

   // Monitor: compares state every falling edge and pops on valid.
   always @(negedge clk) begin
      if (rst) begin
         last_out = 0;
      end else begin
         chk(lfsr_o === 8'(m_lfsr), "lfsr_track", int'(lfsr_o), m_lfsr);
         chk(ifc.busy === (m_left != 0), "busy_track", int'(ifc.busy), int'(m_left != 0));
         if (ifc.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_valid", int'(ifc.random_out), -1);
            end else begin
               int e;
               e = exp_q.pop_front();
               chk(ifc.random_out === 8'(e), "scoreboard_result", int'(ifc.random_out), e);
            end
            last_out = int'(ifc.random_out);
         end else begin
            chk(ifc.random_out === 8'(last_out), "out_stable", int'(ifc.random_out), last_out);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output bit got, output int n, output int nbusy);
      got = 1'b0;
      n = 0;
      nbusy = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (ifc.busy === 1'b1) nbusy++;
         if (ifc.valid === 1'b1) begin
            got = 1'b1;
            n = i;
            break;
         end
      end
   endtask

   task automatic run_req(input logic [7:0] sd, input logic [7:0] rg, input logic [7:0] of,
                          input int exp, input string name);
      bit got;
      int n;
      int nbusy;
      ifc.seed_load = 1'b1;
      ifc.seed = sd;
      tick();
      ifc.req = 1'b1;
      ifc.range = rg;
      ifc.offset = of;
      tick();
      ifc.seed_load = 1'b0;
      ifc.req = 1'b0;
      wait_valid(got, n, nbusy);
      chk(got, {name, "_valid_seen"}, int'(got), 1);
      chk(n == 9, {name, "_latency"}, n, 9);
      chk(nbusy == 8, {name, "_busy_cycles"}, nbusy, 8);
      chk(ifc.random_out === 8'(exp), {name, "_value"}, int'(ifc.random_out), exp);
   endtask

   task automatic count_valids(input int cycles, output int nv);
      nv = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ifc.valid === 1'b1) nv++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int seq[4];
      int first_ret;
      bit saw_zero;
      bit got;
      int n;
      int nbusy;
      int nv;

      seq[0] = 8'h02; seq[1] = 8'h04; seq[2] = 8'h08; seq[3] = 8'h11;
      rst = 1'b1;
      ifc.seed_load = 1'b0; ifc.seed = 8'd0; ifc.req = 1'b0;
      ifc.range = 8'd0; ifc.offset = 8'd0;
      repeat (3) tick();
      rst = 1'b0;
      chk(lfsr_o === 8'h01, "reset_lfsr", int'(lfsr_o), 1);
      chk(ifc.busy === 1'b0, "reset_busy", int'(ifc.busy), 0);
      chk(ifc.valid === 1'b0, "reset_valid", int'(ifc.valid), 0);
      chk(ifc.random_out === 8'd0, "reset_out", int'(ifc.random_out), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk(lfsr_o === 8'(seq[i]), "reset_sequence", int'(lfsr_o), seq[i]);
      end

      // Full period from seed 1.
      ifc.seed_load = 1'b1; ifc.seed = 8'h01;
      tick();
      ifc.seed_load = 1'b0;
      first_ret = 0;
      saw_zero = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         tick();
         if (lfsr_o == 8'd0) saw_zero = 1'b1;
         if (lfsr_o == 8'h01 && first_ret == 0) first_ret = k;
      end
      chk(first_ret == 255, "period_255", first_ret, 255);
      chk(!saw_zero, "never_zero", int'(saw_zero), 0);

      ifc.seed_load = 1'b1; ifc.seed = 8'h00;
      tick();
      ifc.seed_load = 1'b0;
      chk(lfsr_o === 8'h01, "zero_seed", int'(lfsr_o), 1);

      run_req(8'd200, 8'd7,   8'd6,   10,  "mod7");
      run_req(8'd200, 8'd1,   8'd6,   6,   "mod1");
      run_req(8'd200, 8'd255, 8'd6,   206, "mod255");
      run_req(8'd200, 8'd0,   8'd6,   206, "bypass");
      run_req(8'd200, 8'd0,   8'd100, 44,  "wrap");

      // Inputs disturbed mid-CALC must not matter.
      ifc.seed_load = 1'b1; ifc.seed = 8'd200;
      tick();
      ifc.req = 1'b1; ifc.range = 8'd7; ifc.offset = 8'd6;
      tick();
      ifc.req = 1'b0; ifc.seed_load = 1'b0;
      tick(); tick();
      ifc.req = 1'b1; ifc.range = 8'd3; ifc.offset = 8'd50;
      ifc.seed_load = 1'b1; ifc.seed = 8'h55;
      tick();
      ifc.req = 1'b0; ifc.seed_load = 1'b0; ifc.range = 8'd0; ifc.offset = 8'd0;
      wait_valid(got, n, nbusy);
      chk(got, "overlap_valid_seen", int'(got), 1);
      chk(ifc.random_out === 8'd10, "overlap_value", int'(ifc.random_out), 10);
      count_valids(12, nv);
      chk(nv == 0, "overlap_no_extra_valid", nv, 0);

      // Request issued in the valid cycle is accepted.
      ifc.seed_load = 1'b1; ifc.seed = 8'd200;
      tick();
      ifc.req = 1'b1; ifc.range = 8'd7; ifc.offset = 8'd6;
      tick();
      ifc.req = 1'b0; ifc.seed_load = 1'b0;
      wait_valid(got, n, nbusy);
      chk(got, "b2b_first_valid", int'(got), 1);
      ifc.req = 1'b1; ifc.range = 8'd13; ifc.offset = 8'd3;
      tick();
      ifc.req = 1'b0;
      wait_valid(got, n, nbusy);
      chk(got, "b2b_second_valid", int'(got), 1);
      chk(n == 9, "b2b_spacing", n, 9);

      // Reset four cycles into CALC.
      ifc.seed_load = 1'b1; ifc.seed = 8'd200;
      tick();
      ifc.req = 1'b1; ifc.range = 8'd7; ifc.offset = 8'd6;
      tick();
      ifc.req = 1'b0; ifc.seed_load = 1'b0;
      repeat (4) tick();
      #1 rst = 1'b1;
      #1;
      chk(ifc.busy === 1'b0, "midreset_busy", int'(ifc.busy), 0);
      chk(ifc.valid === 1'b0, "midreset_valid", int'(ifc.valid), 0);
      chk(ifc.random_out === 8'd0, "midreset_out", int'(ifc.random_out), 0);
      chk(lfsr_o === 8'h01, "midreset_lfsr", int'(lfsr_o), 1);
      tick();
      rst = 1'b0;
      count_valids(15, nv);
      chk(nv == 0, "midreset_no_valid", nv, 0);
      run_req(8'd200, 8'd255, 8'd6, 206, "after_reset");

      // Randomised traffic checked by the scoreboard.
      for (int i = 0; i < 60; i++) begin
         ifc.seed_load = ($urandom_range(7) == 0);
         ifc.seed = 8'($urandom);
         ifc.req = ($urandom_range(2) != 0);
         ifc.range = ($urandom_range(4) == 0) ? 8'd0 : 8'($urandom);
         ifc.offset = 8'($urandom);
         tick();
         ifc.req = 1'b0;
         ifc.seed_load = 1'b0;
         repeat ($urandom_range(10)) tick();
      end
      for (int i = 0; i < 40 && (exp_q.size() != 0 || ifc.busy === 1'b1); i++) tick();
      tick();
      chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
